magnetron_power_control: RTL and testbench

- Clocked successor to the combinational magnetron control stage in the level-2 microwave controller.
- Adds a cook/pause/done state machine, resume-after-pause, and parametrised power levels.
- Power levels are realised by time-proportioned (PWM) magnetron gating.
- Sits between the keypad/door/timer inputs and the magnetron driver; the timer block owns time_over.

---
 rtl/mag_ctrl_pkg.sv | 19 +
 rtl/mag_pwm_gen.sv | 53 +++++
 rtl/magnetron_power_control.sv | 93 +++++++++
 tb/tb_magnetron_power_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mag_ctrl_pkg.sv
// Shared state encoding and sizing for the magnetron power controller.
// Pure declarations: no latency, no flow control.
package mag_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int PWM_PERIOD_DEF = 10;

    // power_level must be able to express the full period itself
    function automatic int level_w(input int period);
        return $clog2(period + 1);
    endfunction

endpackage

// File: rtl/mag_pwm_gen.sv
// Time-proportioned gate: window counter, saturated level latch, duty compare.
// pwm_out is registered-state compare (0 cycles after counter); no backpressure.
module mag_pwm_gen
    import mag_ctrl_pkg::*;
#(
    parameter int  PWM_PERIOD = PWM_PERIOD_DEF,
    localparam int LEVEL_W    = level_w(PWM_PERIOD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               restart,
    input  logic [LEVEL_W-1:0] power_level,
    output logic               pwm_out
);

    localparam logic [LEVEL_W-1:0] PERIOD_L = LEVEL_W'(PWM_PERIOD);
    localparam logic [LEVEL_W-1:0] CNT_LAST = LEVEL_W'(PWM_PERIOD - 1);

    logic [LEVEL_W-1:0] cnt_q, cnt_d;
    logic [LEVEL_W-1:0] lvl_q, lvl_d;
    logic [LEVEL_W-1:0] level_sat;
    logic               wrap;

    always_comb begin
        level_sat = (power_level > PERIOD_L) ? PERIOD_L : power_level;
        wrap      = run && (cnt_q == CNT_LAST);
        cnt_d     = '0;
        lvl_d     = lvl_q;
        if (restart) begin
            lvl_d = level_sat;
        end else if (run) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            // new level only at a window boundary, so a window is never split
            if (wrap) begin
                lvl_d = level_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            lvl_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign pwm_out = (cnt_q < lvl_q);

endmodule

// File: rtl/magnetron_power_control.sv
// Cook/pause/done controller with PWM power levels and door interlock on mag_on.
// Start press at edge N -> cooking/mag_on in cycle N+1; door open drops mag_on same cycle; no backpressure.
module magnetron_power_control
    import mag_ctrl_pkg::*;
#(
    parameter int  PWM_PERIOD = PWM_PERIOD_DEF,
    localparam int LEVEL_W    = level_w(PWM_PERIOD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Nstart,
    input  logic               Nstop,
    input  logic               Nclear,
    input  logic               door_clo,
    input  logic               time_over,
    input  logic [LEVEL_W-1:0] power_level,
    output logic               mag_on,
    output logic               cooking,
    output logic               paused,
    output logic               done
);

    state_e state_q, state_d;
    logic   nstart_q, nstop_q, nclear_q;
    logic   armed_q;
    logic   start_ev, stop_ev, clear_ev;
    logic   start_ok;
    logic   pwm_run, pwm_restart, pwm_out;

    // A key already held when reset releases is stale, not a new press
    always_ff @(posedge clk) begin
        if (reset) begin
            nstart_q <= 1'b1;
            nstop_q  <= 1'b1;
            nclear_q <= 1'b1;
            armed_q  <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            nstart_q <= Nstart;
            nstop_q  <= Nstop;
            nclear_q <= Nclear;
            armed_q  <= 1'b1;
            state_q  <= state_d;
        end
    end

    assign start_ev = armed_q && nstart_q && !Nstart;
    assign stop_ev  = armed_q && nstop_q  && !Nstop;
    assign clear_ev = armed_q && nclear_q && !Nclear;
    assign start_ok = start_ev && door_clo && !time_over;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_COOK;
            end
            ST_COOK: begin
                if (time_over)              state_d = ST_DONE;
                else if (!door_clo || stop_ev) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (stop_ev || clear_ev) state_d = ST_IDLE;
                else if (start_ok)       state_d = ST_COOK;
            end
            ST_DONE: begin
                if (stop_ev || clear_ev || !door_clo) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter only advances across edges that stay in COOK, so it reads 0 elsewhere
    assign pwm_restart = (state_d == ST_COOK) && (state_q != ST_COOK);
    assign pwm_run     = (state_d == ST_COOK) && (state_q == ST_COOK);

    mag_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_pwm (
        .clk         (clk),
        .reset       (reset),
        .run         (pwm_run),
        .restart     (pwm_restart),
        .power_level (power_level),
        .pwm_out     (pwm_out)
    );

    assign cooking = !reset && (state_q == ST_COOK);
    assign paused  = !reset && (state_q == ST_PAUSE);
    assign done    = !reset && (state_q == ST_DONE);
    assign mag_on  = cooking && pwm_out && door_clo;

endmodule

// File: tb/tb_magnetron_power_control.sv
// Directed-vector bench for magnetron_power_control at PWM_PERIOD = 10.
// Inputs change 1 time unit after posedge; outputs checked before the next edge.
module tb_magnetron_power_control;

    localparam int P  = 10;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          Nstart, Nstop, Nclear;
    logic          door_clo, time_over;
    logic [LW-1:0] power_level;
    logic          mag_on, cooking, paused, done;

    int n_vec = 0;
    int n_err = 0;

    magnetron_power_control #(.PWM_PERIOD(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .Nstart      (Nstart),
        .Nstop       (Nstop),
        .Nclear      (Nclear),
        .door_clo    (door_clo),
        .time_over   (time_over),
        .power_level (power_level),
        .mag_on      (mag_on),
        .cooking     (cooking),
        .paused      (paused),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // keys: bit0 start, bit1 stop, bit2 clear; held low for exactly one edge
    task automatic press(input logic [2:0] keys);
        Nstart = !keys[0];
        Nstop  = !keys[1];
        Nclear = !keys[2];
        step(1);
        Nstart = 1'b1;
        Nstop  = 1'b1;
        Nclear = 1'b1;
    endtask

    task automatic sample_pattern(input int n, output logic [31:0] pat);
        pat = '0;
        for (int k = 0; k < n; k++) begin
            pat[k] = mag_on;
            step(1);
        end
    endtask

    logic [31:0] pat;
    int          ones;

    initial begin
        reset = 1'b1; Nstart = 1'b1; Nstop = 1'b1; Nclear = 1'b1;
        door_clo = 1'b1; time_over = 1'b0; power_level = '0;
        step(2);
        chk("reset_status", {28'd0, mag_on, cooking, paused, done}, 32'h0);
        reset = 1'b0;
        step(1);
        chk("idle_status", {28'd0, mag_on, cooking, paused, done}, 32'h0);

        // full power, then timer expiry and door-open exit from DONE
        power_level = 4'd10;
        press(3'b001);
        chk("full_first_cycle", {30'd0, cooking, mag_on}, 32'h3);
        ones = 1;
        for (int k = 0; k < 24; k++) begin
            step(1);
            ones += int'(mag_on);
        end
        chk("full_25_cycles_on", ones, 25);
        time_over = 1'b1;
        step(1);
        chk("time_over_done", {29'd0, mag_on, cooking, done}, 32'h1);
        time_over = 1'b0;
        door_clo  = 1'b0;
        step(1);
        chk("done_door_idle", {29'd0, cooking, paused, done}, 32'h0);
        door_clo = 1'b1;

        // half power, then level change mid-window
        power_level = 4'd5;
        press(3'b001);
        sample_pattern(10, pat);
        chk("half_window", pat, 32'h01F);
        step(2);
        power_level = 4'd2;
        sample_pattern(18, pat);
        chk("level_change_next_wrap", pat, 32'h307);

        // door open mid-cook: interlock is combinational
        chk("cook_before_door", {31'd0, mag_on}, 32'h1);
        door_clo = 1'b0;
        #1;
        chk("door_drop_same_cycle", {30'd0, cooking, mag_on}, 32'h2);
        step(1);
        chk("door_to_pause", {30'd0, paused, cooking}, 32'h2);
        press(3'b001);
        chk("start_door_open_pause", {30'd0, paused, cooking}, 32'h2);
        door_clo    = 1'b1;
        power_level = 4'd3;
        step(1);
        press(3'b001);
        sample_pattern(4, pat);
        chk("resume_window_restart", pat, 32'h7);

        // stop/resume/stop/stop
        press(3'b010);
        chk("stop_to_pause", {30'd0, paused, mag_on}, 32'h2);
        step(1);
        press(3'b001);
        chk("resume_cook", {31'd0, cooking}, 32'h1);
        step(1);
        press(3'b010);
        chk("second_stop_pause", {31'd0, paused}, 32'h1);
        step(1);
        press(3'b010);
        chk("stop_to_idle", {28'd0, mag_on, cooking, paused, done}, 32'h0);

        // clear ignored in COOK; stop beats start in PAUSE
        step(1);
        press(3'b001);
        step(1);
        press(3'b100);
        chk("clear_ignored_cook", {30'd0, cooking, paused}, 32'h2);
        step(1);
        press(3'b010);
        step(1);
        press(3'b011);
        chk("stop_beats_start", {30'd0, cooking, paused}, 32'h0);

        // blocked starts in IDLE
        step(1);
        door_clo = 1'b0;
        press(3'b001);
        chk("idle_start_door_open", {30'd0, cooking, mag_on}, 32'h0);
        door_clo  = 1'b1;
        time_over = 1'b1;
        step(1);
        press(3'b001);
        chk("idle_start_time_over", {30'd0, cooking, mag_on}, 32'h0);
        time_over = 1'b0;

        // level 0 stays dark; oversize level saturates to full
        power_level = 4'd0;
        step(1);
        press(3'b001);
        chk("level0_cooking", {31'd0, cooking}, 32'h1);
        power_level = 4'd15;
        sample_pattern(10, pat);
        chk("level0_window", pat, 32'h0);
        sample_pattern(10, pat);
        chk("level_saturated", pat, 32'h3FF);

        // reset mid-cook with start held through release
        reset  = 1'b1;
        Nstart = 1'b0;
        #1;
        chk("reset_gates_outputs", {30'd0, cooking, mag_on}, 32'h0);
        step(1);
        chk("reset_to_idle", {30'd0, cooking, mag_on}, 32'h0);
        reset = 1'b0;
        step(3);
        chk("held_start_no_event", {30'd0, cooking, mag_on}, 32'h0);
        Nstart = 1'b1;
        step(1);
        press(3'b001);
        chk("start_after_reset", {30'd0, cooking, mag_on}, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
